fork_join_sched: RTL and testbench
==================================

FORK_JOIN_SCHED -- requirements
Module: fork_join_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of value1, value2, ret1 and ret2.
REQ-002 SHALL have parameter CNT_W, default 8: width of the delay inputs and branch counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port value1, input, WIDTH: branch A source and trigger source.
REQ-006 SHALL have port value2, input, WIDTH: branch B source and trigger source.
REQ-007 SHALL have port dly_a, input, CNT_W: branch A delay in cycles, latched at launch.
REQ-008 SHALL have port dly_b, input, CNT_W: branch B delay in cycles, latched at launch.
REQ-009 SHALL have port ret1, output, WIDTH: branch A result register.
REQ-010 SHALL have port ret2, output, WIDTH: branch B result register.
REQ-011 SHALL have port busy, output, 1: fork in progress.
REQ-012 SHALL have port done, output, 1: one-cycle join pulse.
REQ-013 SHALL have port b_skip, output, 1: one-cycle pulse, branch B abandoned because ret1 did not change.

Function
REQ-014 SHALL keep registered copies of value1/value2, updated every cycle; trigger = (value1 != copy1) or (value2 != copy2).
REQ-015 SHALL launch the fork, from IDLE only, on the edge where the trigger is seen; triggers while busy are discarded and not queued.
REQ-016 SHALL use FSM states IDLE, RUN and JOIN, with transitions IDLE->RUN on trigger, RUN->JOIN when both branches are finished, and JOIN->IDLE unconditionally.
REQ-017 SHALL hold busy=1 in RUN and JOIN, and pulse done=1 in JOIN only.
REQ-018 Branch A SHALL write ret1 <= value1 as currently sampled, dly_a edges after the launch edge; dly_a=0 SHALL behave as 1.
REQ-019 Branch B SHALL arm on the edge where ret1 changes value, then write ret2 <= value2 as currently sampled dly_b edges later; dly_b=0 SHALL behave as 1.
REQ-020 If the branch A write leaves ret1 unchanged, branch B SHALL be marked finished without a write, and b_skip SHALL pulse in JOIN.
REQ-021 SHALL leave ret1 and ret2 held whenever their branch is not writing.
REQ-022 SHALL compute each branch count as an unsigned CNT_W down-counter with no wrap; maximum delay is 2^CNT_W-1.
REQ-023 SHALL ignore a trigger arriving in the JOIN cycle, so the earliest relaunch is on a change seen in IDLE.

Reset
REQ-024 While rst_n=0 at an edge: ret1=0, ret2=0, busy=0, done=0, b_skip=0, state IDLE, counters 0.
REQ-025 While rst_n=0, the value copies SHALL load the current inputs, so no spurious trigger occurs after release.
REQ-026 Reset mid-RUN SHALL abort both branches with no done pulse and no further writes.

Structure
REQ-027 Package fork_join_sched_pkg SHALL hold the state enum (IDLE/RUN/JOIN) and the default WIDTH/CNT_W constants.
REQ-028 SHALL instantiate sub-module fj_branch_timer (load, count-down, expire pulse) twice, once per branch.
REQ-029 Total RTL SHALL be approximately 150-250 lines.

Verification
REQ-030 Reset, then value1=1, value2=2, dly_a=10, dly_b=12 (launch edge L) -> ret1=1 at L+10; ret2=0 at L+12; ret2=2 and done=1 at L+22; busy=0 at L+23.
REQ-031 During the REQ-030 run, value1=5 at L+5 -> no second launch; ret1=5 at L+10; after done the block stays IDLE.
REQ-032 With ret1=1 and value1=1, change value2 to 3, dly_a=4 -> ret1 unchanged; b_skip=1 and done=1 at L+5; ret2 unchanged.
REQ-033 With dly_a=0 and dly_b=0 -> ret1 written at L+1, ret2 written at L+2, done at L+2.
REQ-034 rst_n=0 at L+5 of a run -> ret1=0, ret2=0, busy=0, no done; after release with inputs static -> no launch.
REQ-035 Value change coinciding with the JOIN cycle -> no relaunch; a later change seen in IDLE -> launch.

Source files
------------

// File: rtl/fork_join_sched_pkg.sv
// Shared types and default sizes for the fork/join scheduler.
// Holds the FSM state enum and the default WIDTH/CNT_W values.
package fork_join_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JOIN = 2'd2
  } state_e;

endpackage

// File: rtl/fj_branch_timer.sv
// Branch delay timer: load a delay (0 treated as 1), count down,
// and flag the cycle in which the branch must act.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : load i_dly into the counter
//   i_dly      : delay in cycles
//   o_expire   : high in the cycle whose rising edge performs the write
module fj_branch_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_dly,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_dly == '0) ? CNT_W'(1) : i_dly;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A count of 1 means the next edge is the one that is dly edges
  // after the load edge.
  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: an input change launches branch A (writes ret1),
// branch B follows once ret1 changes (writes ret2), then a join pulse.
//   clk, rst_n       : clock, synchronous active-low reset
//   value1, value2   : branch sources and trigger sources
//   dly_a, dly_b     : branch delays, captured at launch
//   ret1, ret2       : branch result registers
//   busy, done       : fork in progress, one-cycle join pulse
//   b_skip           : join pulse where branch B was abandoned
module fork_join_sched
  import fork_join_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic [CNT_W-1:0] dly_a,
  input  logic [CNT_W-1:0] dly_b,
  output logic [WIDTH-1:0] ret1,
  output logic [WIDTH-1:0] ret2,
  output logic             busy,
  output logic             done,
  output logic             b_skip
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_copy1;
  logic [WIDTH-1:0] r_copy2;
  logic [WIDTH-1:0] r_ret1;
  logic [WIDTH-1:0] r_ret2;
  logic [CNT_W-1:0] r_dly_b;
  logic             r_a_fin;
  logic             r_b_fin;
  logic             r_skip;

  logic w_trig;
  logic w_launch;
  logic w_a_tmr;
  logic w_b_tmr;
  logic w_a_exp;
  logic w_b_exp;
  logic w_a_chg;
  logic w_b_load;

  assign w_trig   = (value1 != r_copy1) || (value2 != r_copy2);
  assign w_launch = (r_state == IDLE) && w_trig;
  assign w_a_exp  = w_a_tmr && (r_state == RUN);
  assign w_b_exp  = w_b_tmr && (r_state == RUN);
  assign w_a_chg  = (value1 != r_ret1);
  assign w_b_load = w_a_exp && w_a_chg;

  fj_branch_timer #(.CNT_W(CNT_W)) u_tmr_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_launch),
    .i_dly   (dly_a),
    .o_expire(w_a_tmr)
  );

  fj_branch_timer #(.CNT_W(CNT_W)) u_tmr_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_b_load),
    .i_dly   (r_dly_b),
    .o_expire(w_b_tmr)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_trig) w_next = RUN;
      RUN: begin
        // A skip is registered first, so skip joins one edge later.
        if (r_a_fin && (r_b_fin || w_b_exp)) w_next = JOIN;
      end
      JOIN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_copy1 <= value1;
      r_copy2 <= value2;
      r_ret1  <= '0;
      r_ret2  <= '0;
      r_dly_b <= '0;
      r_a_fin <= 1'b0;
      r_b_fin <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_copy1 <= value1;
      r_copy2 <= value2;
      if (w_launch) begin
        r_dly_b <= dly_b;
        r_a_fin <= 1'b0;
        r_b_fin <= 1'b0;
        r_skip  <= 1'b0;
      end
      if (w_a_exp) begin
        r_a_fin <= 1'b1;
        if (w_a_chg) begin
          r_ret1 <= value1;
        end else begin
          r_b_fin <= 1'b1;
          r_skip  <= 1'b1;
        end
      end
      if (w_b_exp) begin
        r_ret2  <= value2;
        r_b_fin <= 1'b1;
      end
    end
  end

  assign ret1   = r_ret1;
  assign ret2   = r_ret2;
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == JOIN);
  assign b_skip = (r_state == JOIN) && r_skip;

endmodule

// File: tb/tb_fork_join_sched.sv
// Self-checking bench for fork_join_sched: table vectors, directed
// corner sequences and random stimulus against an event-time model.
module tb_fork_join_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] value1, value2;
  logic [7:0] dly_a, dly_b;
  logic [3:0] ret1, ret2;
  logic       busy, done, b_skip;

  int n_vec = 0;
  int n_err = 0;

  fork_join_sched #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value1(value1),
    .value2(value2),
    .dly_a (dly_a),
    .dly_b (dly_b),
    .ret1  (ret1),
    .ret2  (ret2),
    .busy  (busy),
    .done  (done),
    .b_skip(b_skip)
  );

  always #5 clk = ~clk;

  // Reference model: absolute cycle times of each scheduled event.
  int         c = 0;
  logic       m_busy = 0;
  logic       m_skip = 0;
  int         tA = -1, tB = -1, tJ = -1, dbm = 1;
  logic [3:0] mc1 = 0, mc2 = 0, mr1 = 0, mr2 = 0;
  logic       m_done, m_bskip;

  task automatic model_step();
    c++;
    if (!rst_n) begin
      mr1 = 0; mr2 = 0; m_busy = 0; m_skip = 0;
      tA = -1; tB = -1; tJ = -1;
    end else if (!m_busy) begin
      if (value1 != mc1 || value2 != mc2) begin
        m_busy = 1; m_skip = 0;
        tA = c + ((dly_a == 0) ? 1 : int'(dly_a));
        dbm = (dly_b == 0) ? 1 : int'(dly_b);
        tB = -1; tJ = -1;
      end
    end else if (tJ >= 0 && c == tJ + 1) begin
      m_busy = 0;
    end else begin
      if (c == tA) begin
        if (value1 != mr1) begin
          mr1 = value1; tB = c + dbm;
        end else begin
          m_skip = 1; tJ = c + 1;
        end
      end
      if (c == tB) begin
        mr2 = value2; tJ = c;
      end
    end
    mc1 = value1; mc2 = value2;
    m_done  = m_busy && (c == tJ);
    m_bskip = m_done && m_skip;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_ret1", ret1, mr1);
    chk("m_ret2", ret2, mr2);
    chk("m_busy", busy, m_busy);
    chk("m_done", done, m_done);
    chk("m_bskip", b_skip, m_bskip);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v1, v2;
    logic [7:0] da, db;
    logic [3:0] r1, r2;
    logic       bz, dn, sk;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst_n = 0; value1 = 0; value2 = 0; dly_a = 0; dly_b = 0;
    // Zero delays: write at L+1, L+2, join at L+2; then a skip run.
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 7, 0, 0, 1, 7, 1, 1, 0};
    tbl[5]  = '{1, 1, 7, 0, 0, 1, 7, 0, 0, 0};
    tbl[6]  = '{1, 1, 7, 0, 0, 1, 7, 0, 0, 0};
    tbl[7]  = '{1, 1, 3, 0, 0, 1, 7, 1, 0, 0};
    tbl[8]  = '{1, 1, 3, 0, 0, 1, 7, 1, 0, 0};
    tbl[9]  = '{1, 1, 3, 0, 0, 1, 7, 1, 1, 1};
    tbl[10] = '{1, 1, 3, 0, 0, 1, 7, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst; value1 = tbl[i].v1; value2 = tbl[i].v2;
      dly_a = tbl[i].da; dly_b = tbl[i].db;
      tick();
      chk("t_ret1", ret1, tbl[i].r1);
      chk("t_ret2", ret2, tbl[i].r2);
      chk("t_busy", busy, tbl[i].bz);
      chk("t_done", done, tbl[i].dn);
      chk("t_skip", b_skip, tbl[i].sk);
    end

    // Basic fork: dly 10/12.
    rst_n = 0; value1 = 0; value2 = 0; tick(); tick();
    chk("rst_ret1", ret1, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1; tick();
    chk("rel_busy", busy, 0);
    value1 = 1; value2 = 2; dly_a = 10; dly_b = 12; tick();
    chk("L_busy", busy, 1);
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 9)  chk("a9_ret1", ret1, 0);
      if (k == 10) chk("a10_ret1", ret1, 1);
      if (k == 12) chk("b12_ret2", ret2, 0);
      if (k == 21) chk("b21_done", done, 0);
      if (k == 22) begin
        chk("b22_ret2", ret2, 2);
        chk("b22_done", done, 1);
      end
      if (k == 23) chk("e23_busy", busy, 0);
    end

    // Busy-time change: no relaunch, ret1 takes the late value.
    value1 = 3; tick();
    for (int k = 1; k <= 28; k++) begin
      if (k == 5) value1 = 5;
      tick();
      if (k == 5)  chk("nq_busy", busy, 1);
      if (k == 10) chk("late_ret1", ret1, 5);
      if (k == 22) chk("late_done", done, 1);
      if (k > 22)  chk("stay_idle", busy, 0);
    end

    // Unchanged ret1: branch B skipped, join one edge after A.
    value2 = 3; dly_a = 4; tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) chk("sk4_done", done, 0);
      if (k == 5) begin
        chk("sk5_done", done, 1);
        chk("sk5_skip", b_skip, 1);
        chk("sk5_ret1", ret1, 5);
        chk("sk5_ret2", ret2, 2);
      end
    end

    // Reset mid-run aborts; static inputs after release: no launch.
    value1 = 9; dly_a = 10; tick();
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 0; tick();
    chk("ab_ret1", ret1, 0);
    chk("ab_ret2", ret2, 0);
    chk("ab_busy", busy, 0);
    rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ab_idle", busy, 0);
      chk("ab_nodone", done, 0);
    end

    // Change in the JOIN cycle is dropped; change in IDLE launches.
    value1 = 4; dly_a = 1; dly_b = 1; tick();
    tick(); tick();
    chk("j_done", done, 1);
    value2 = 11; tick();
    chk("j_norelaunch", busy, 0);
    tick();
    chk("j_idle", busy, 0);
    value1 = 6; tick();
    chk("j_launch", busy, 1);
    for (int k = 0; k < 4; k++) tick();

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 5) == 0) value1 = 4'($urandom);
      if ($urandom_range(0, 5) == 0) value2 = 4'($urandom);
      dly_a = ($urandom_range(0, 40) == 0) ? 8'($urandom)
                                           : 8'($urandom_range(0, 6));
      dly_b = ($urandom_range(0, 40) == 0) ? 8'($urandom)
                                           : 8'($urandom_range(0, 6));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
